alu_exec_seq: RTL and testbench
===============================

// Module: alu_exec_seq
// PURPOSE
//  Parametrised ALU control + execute unit for the multi-cycle CPU.
//  - Decodes ALUOp/OpCode/FUNCT into a 4-bit op code, then executes it.
//  - Single-cycle ops complete in 1 clock.
//  - Iterative MULTU/DIVU run WIDTH clocks and write the HI/LO registers.
//  - Start/busy/done handshake lets the control FSM stall the EX state.
//  - Illegal decodes are flagged explicitly instead of holding a stale code.
// PARAMETERS
//  WIDTH   32               datapath width; even, >=8
//  SH_W    $clog2(WIDTH)    shift-amount width
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      launch op; sampled only when busy=0
//  ALUOp     in   2      00 ADD, 01 SUB, 11 IMM (decode by OpCode), 10 RTYPE (decode by FUNCT)
//  OpCode    in   6      instruction opcode
//  FUNCT     in   6      R-type function field
//  a         in   WIDTH  operand A (rs)
//  b         in   WIDTH  operand B (rt/imm)
//  shamt     in   SH_W   shift amount for SLL/SRL
//  alu_ctrl  out  4      registered decoded op code
//  result    out  WIDTH  registered result
//  zero      out  1      result==0, registered with result
//  hi, lo    out  WIDTH  MULTU/DIVU result registers
//  busy      out  1      iterative op in progress
//  done      out  1      one-cycle completion pulse
//  illegal   out  1      last started op decoded illegal; held until next start
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; alu_ctrl=4'hF; result, hi, lo = 0; zero=1;
//    busy, done, illegal = 0. Reset during ITER aborts the op; hi/lo cleared.
//  Decode:
//    ALUOp 00 -> 2; 01 -> 6.
//    ALUOp 11: OpCode 15 (LUI) -> 5; OpCode 10 (SLTI) -> 7; else 15.
//    ALUOp 10: FUNCT 36/37/32/34/42/39/38/0/2 -> 0/1/2/6/7/8/9/3/4;
//      FUNCT 25 (MULTU) -> 10; FUNCT 27 (DIVU) -> 11; else 15.
//  Ops (mod 2^WIDTH, no overflow trap):
//    0 AND, 1 OR, 2 ADD, 6 SUB, 8 NOR, 9 XOR
//    3 b<<shamt, 4 b>>shamt (logical)
//    5 LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}
//    7 SLT: signed a<b -> 1, else 0
//    15 illegal: result=0, illegal=1
//  FSM states:
//    IDLE: busy=0. start with single op or illegal -> register alu_ctrl,
//      result, zero, illegal; go DONE.
//      start with op 10/11 -> load iteration regs, count=0; go ITER.
//    ITER: busy=1; one shift-add (MULTU) or restoring-subtract (DIVU) step
//      per clock; count++. After step WIDTH-1 -> DONE.
//    DONE: done=1 for exactly this cycle, busy=0; results valid.
//      Always -> IDLE, unless start=1, which is accepted as IDLE would.
//  Latency (start edge -> done high): single op = 1 clk; MULTU/DIVU = WIDTH+1 clk.
//  MULTU: {hi,lo} = a*b unsigned, 2*WIDTH bits. result=lo; zero from lo.
//  DIVU: lo = a/b, hi = a%b.
//    b==0: lo = all ones, hi = a, illegal=0.
//  start while busy=1: ignored, no side effects.
//  Operands are latched at start; changes to a/b during ITER have no effect.
//  hi/lo keep their values across single-cycle ops.
// TESTING
//  Reset: drive rst mid-ITER of MULTU -> busy=0, done=0, hi=lo=0, alu_ctrl=F at once.
//  RTYPE FUNCT=34, a=5, b=7 -> done 1 clk later; result=32'hFFFFFFFE, zero=0.
//  Decode sweep across all ALUOp/OpCode/FUNCT combos:
//    codes match the table above; FUNCT=63 -> illegal=1, result=0.
//  MULTU a=32'hFFFFFFFF, b=2:
//    busy for 32 clks; done at clk 33; hi=1, lo=32'hFFFFFFFE.
//  DIVU a=100, b=7 -> lo=14, hi=2.
//  DIVU a=9, b=0 -> lo=32'hFFFFFFFF, hi=9.
//  Back-to-back and boundary starts:
//    start held high during ITER -> ignored.
//    start in DONE cycle with SLTI, a=-1, b=0 -> result=1 next clk.
//    SLL with shamt=31, b=1 -> 32'h80000000.

Source files
------------

// File: rtl/alu_exec_seq_if.sv
// rtl/alu_exec_seq_if.sv - issue/result bundle between the control FSM and the ALU execute unit
interface alu_exec_seq_if #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) ();
  logic             start;
  logic [1:0]       ALUOp;
  logic [5:0]       OpCode;
  logic [5:0]       FUNCT;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SH_W-1:0]  shamt;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, ALUOp, OpCode, FUNCT, a, b, shamt,
    input  alu_ctrl, result, zero, hi, lo, busy, done, illegal
  );

  modport slave (
    input  start, ALUOp, OpCode, FUNCT, a, b, shamt,
    output alu_ctrl, result, zero, hi, lo, busy, done, illegal
  );
endinterface

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - ALU decode + execute with iterative MULTU/DIVU and start/busy/done handshake
module alu_exec_seq #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst,
  alu_exec_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_LUI   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_ILL   = 4'd15;

  state_t           state_q, state_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [SH_W-1:0]  count_q, count_d;
  logic             is_div_q, is_div_d;

  logic [3:0]       dec_ctrl;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             accept;

  always_comb begin
    dec_ctrl = OP_ILL;
    case (bus.ALUOp)
      2'b00: dec_ctrl = OP_ADD;
      2'b01: dec_ctrl = OP_SUB;
      2'b11: begin
        case (bus.OpCode)
          6'd15:   dec_ctrl = OP_LUI;
          6'd10:   dec_ctrl = OP_SLT;
          default: dec_ctrl = OP_ILL;
        endcase
      end
      default: begin
        case (bus.FUNCT)
          6'd36:   dec_ctrl = OP_AND;
          6'd37:   dec_ctrl = OP_OR;
          6'd32:   dec_ctrl = OP_ADD;
          6'd34:   dec_ctrl = OP_SUB;
          6'd42:   dec_ctrl = OP_SLT;
          6'd39:   dec_ctrl = OP_NOR;
          6'd38:   dec_ctrl = OP_XOR;
          6'd0:    dec_ctrl = OP_SLL;
          6'd2:    dec_ctrl = OP_SRL;
          6'd25:   dec_ctrl = OP_MULTU;
          6'd27:   dec_ctrl = OP_DIVU;
          default: dec_ctrl = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    single_res = '0;
    case (dec_ctrl)
      OP_AND:  single_res = bus.a & bus.b;
      OP_OR:   single_res = bus.a | bus.b;
      OP_ADD:  single_res = bus.a + bus.b;
      OP_SUB:  single_res = bus.a - bus.b;
      OP_NOR:  single_res = ~(bus.a | bus.b);
      OP_XOR:  single_res = bus.a ^ bus.b;
      OP_SLL:  single_res = bus.b << bus.shamt;
      OP_SRL:  single_res = bus.b >> bus.shamt;
      OP_LUI:  single_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  single_res = ($signed(bus.a) < $signed(bus.b)) ? WIDTH'(1) : '0;
      default: single_res = '0;
    endcase
  end

  // MULTU: acc/quo form a 2W-bit product shifted right each step.
  // DIVU: acc is the partial remainder, quo shifts dividend out and quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q, quo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ok   = (div_sh >= {1'b0, opb_q});
    if (is_div_q) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {quo_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  assign accept = bus.start && (state_q != S_ITER);

  always_comb begin
    state_d    = state_q;
    alu_ctrl_d = alu_ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    illegal_d  = illegal_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    opb_d      = opb_q;
    count_d    = count_q;
    is_div_d   = is_div_q;

    // DONE accepts a new start exactly like IDLE, allowing back-to-back issue.
    if (accept) begin
      alu_ctrl_d = dec_ctrl;
      if (dec_ctrl == OP_MULTU || dec_ctrl == OP_DIVU) begin
        acc_d     = '0;
        quo_d     = bus.a;
        opb_d     = bus.b;
        is_div_d  = (dec_ctrl == OP_DIVU);
        count_d   = '0;
        illegal_d = 1'b0;
        state_d   = S_ITER;
      end else begin
        result_d  = single_res;
        zero_d    = (single_res == '0);
        illegal_d = (dec_ctrl == OP_ILL);
        state_d   = S_DONE;
      end
    end else begin
      case (state_q)
        S_ITER: begin
          acc_d   = step_hi;
          quo_d   = step_lo;
          count_d = count_q + 1'b1;
          if (count_q == SH_W'(WIDTH - 1)) begin
            hi_d     = step_hi;
            lo_d     = step_lo;
            result_d = step_lo;
            zero_d   = (step_lo == '0);
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_ctrl_q <= OP_ILL;
      result_q   <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      illegal_q  <= 1'b0;
      acc_q      <= '0;
      quo_q      <= '0;
      opb_q      <= '0;
      count_q    <= '0;
      is_div_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_ctrl_q <= alu_ctrl_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      illegal_q  <= illegal_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      opb_q      <= opb_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
    end
  end

  assign bus.alu_ctrl = alu_ctrl_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.illegal  = illegal_q;
  assign bus.busy     = (state_q == S_ITER);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - scoreboard bench for alu_exec_seq (WIDTH=32)
module tb_alu_exec_seq;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_seq_if #(.WIDTH(32)) ifc ();

  alu_exec_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [3:0] ref_decode(input logic [1:0] aluop, input logic [5:0] opc,
                                            input logic [5:0] fn);
    case (aluop)
      2'b00: return 4'd2;
      2'b01: return 4'd6;
      2'b11: return (opc == 6'd15) ? 4'd5 : (opc == 6'd10) ? 4'd7 : 4'd15;
      default: begin
        case (fn)
          6'd36: return 4'd0;
          6'd37: return 4'd1;
          6'd32: return 4'd2;
          6'd34: return 4'd6;
          6'd42: return 4'd7;
          6'd39: return 4'd8;
          6'd38: return 4'd9;
          6'd0:  return 4'd3;
          6'd2:  return 4'd4;
          6'd25: return 4'd10;
          6'd27: return 4'd11;
          default: return 4'd15;
        endcase
      end
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    logic [63:0] p;
    e.ctrl = ref_decode(aluop, opc, fn);
    e.hi   = mdl_hi;
    e.lo   = mdl_lo;
    e.ill  = 1'b0;
    e.lat  = 1;
    e.res  = 32'd0;
    case (e.ctrl)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  e.res = b << sh;
      4'd4:  e.res = b >> sh;
      4'd5:  e.res = {b[15:0], 16'h0000};
      4'd6:  e.res = a - b;
      4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.res = ~(a | b);
      4'd9:  e.res = a ^ b;
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = 33;
      end
      4'd11: begin
        if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
        e.res = e.lo; e.lat = 33;
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Drives start now; returns at the sample point where done was seen (or the bound ran out).
  task automatic issue(input logic [1:0] aluop, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input bit hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   busy_cnt;
    e = model(aluop, opc, fn, a, b, sh);
    mdl_hi = e.hi;
    mdl_lo = e.lo;
    sb.push_back(e);
    ifc.ALUOp = aluop; ifc.OpCode = opc; ifc.FUNCT = fn;
    ifc.a = a; ifc.b = b; ifc.shamt = sh;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      ifc.ALUOp = 2'b00; ifc.a = $urandom; ifc.b = $urandom;
    end else begin
      ifc.start = 1'b0;
    end
    lat = 1;
    busy_cnt = 0;
    while (!ifc.done && lat < 60) begin
      if (ifc.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    ifc.start = 1'b0;
    got = sb.pop_front();
    chk("done_seen", 64'(ifc.done), 64'd1);
    chk("latency", 64'(lat), 64'(got.lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(got.lat - 1));
    chk("alu_ctrl", 64'(ifc.alu_ctrl), 64'(got.ctrl));
    chk("result", 64'(ifc.result), 64'(got.res));
    chk("zero", 64'(ifc.zero), 64'(got.zero));
    chk("illegal", 64'(ifc.illegal), 64'(got.ill));
    chk("hi", 64'(ifc.hi), 64'(got.hi));
    chk("lo", 64'(ifc.lo), 64'(got.lo));
  endtask

  task automatic op(input logic [1:0] aluop, input logic [5:0] opc, input logic [5:0] fn,
                    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    issue(aluop, opc, fn, a, b, sh, 1'b0);
  endtask

  initial begin
    logic [31:0] keep_res;
    n_total = 0;
    n_pass  = 0;
    mdl_hi  = 32'd0;
    mdl_lo  = 32'd0;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.ALUOp = 2'b00; ifc.OpCode = 6'd0; ifc.FUNCT = 6'd0;
    ifc.a = 32'd0; ifc.b = 32'd0; ifc.shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_ctrl", 64'(ifc.alu_ctrl), 64'hF);
    chk("rst_result", 64'(ifc.result), 64'd0);
    chk("rst_zero", 64'(ifc.zero), 64'd1);
    chk("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    chk("rst_busy_done_ill", 64'({ifc.busy, ifc.done, ifc.illegal}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load hi/lo, then abort a MULTU mid-iteration with reset.
    op(2'b10, 6'd0, 6'd25, 32'd12345, 32'd777, 5'd0);
    @(negedge clk);
    ifc.ALUOp = 2'b10; ifc.FUNCT = 6'd25; ifc.a = 32'hFFFF_FFFF; ifc.b = 32'd2;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_iter_busy", 64'(ifc.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy_done", 64'({ifc.busy, ifc.done}), 64'd0);
    chk("abort_hilo", {ifc.hi, ifc.lo}, 64'd0);
    chk("abort_alu_ctrl", 64'(ifc.alu_ctrl), 64'hF);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;

    op(2'b10, 6'd0, 6'd34, 32'd5, 32'd7, 5'd0);
    op(2'b00, 6'd0, 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    op(2'b01, 6'd0, 6'd0, 32'd9, 32'd9, 5'd0);
    for (int o = 0; o < 64; o++) op(2'b11, 6'(o), 6'd0, $urandom, $urandom, 5'($urandom));
    for (int f = 0; f < 64; f++) op(2'b10, 6'd0, 6'(f), $urandom, $urandom, 5'($urandom));

    op(2'b10, 6'd0, 6'd25, 32'hFFFF_FFFF, 32'd2, 5'd0);
    op(2'b10, 6'd0, 6'd36, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    op(2'b10, 6'd0, 6'd27, 32'd100, 32'd7, 5'd0);
    op(2'b10, 6'd0, 6'd27, 32'd9, 32'd0, 5'd0);
    op(2'b10, 6'd0, 6'd27, 32'd3, 32'd10, 5'd0);

    // start held high through ITER with operands changing must not disturb the DIVU
    @(negedge clk);
    issue(2'b10, 6'd0, 6'd27, 32'hDEAD_BEEF, 32'd1000, 5'd0, 1'b1);
    keep_res = ifc.result;
    @(posedge clk); #1;
    chk("hold_back_idle", 64'({ifc.busy, ifc.done}), 64'd0);
    chk("hold_result_kept", 64'(ifc.result), 64'(keep_res));

    // back-to-back: start accepted in the DONE cycle
    op(2'b00, 6'd0, 6'd0, 32'd3, 32'd4, 5'd0);
    issue(2'b11, 6'd10, 6'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0);
    issue(2'b10, 6'd0, 6'd63, 32'd1, 32'd2, 5'd0, 1'b0);
    issue(2'b10, 6'd0, 6'd25, 32'd65536, 32'd65536, 5'd0, 1'b0);

    op(2'b10, 6'd0, 6'd0, 32'd0, 32'd1, 5'd31);
    op(2'b10, 6'd0, 6'd2, 32'd0, 32'h8000_0000, 5'd31);
    op(2'b11, 6'd15, 6'd0, 32'd0, 32'h1234_ABCD, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
